// File: rtl/led_chase_seq_if.sv
// led_chase_seq_if: control inputs and duty outputs shared by the sequencer and the PWM stages
interface led_chase_seq_if #(
    parameter int CHANNELS = 8,
    parameter int DUTY_W   = 8
);
    logic                       enable;
    logic                       pwm_period_end;
    logic [CHANNELS*DUTY_W-1:0] duty;
    logic                       duty_update;
    logic [2:0]                 state;
    modport master (output enable, pwm_period_end, input duty, duty_update, state);
    modport slave  (input enable, pwm_period_end, output duty, duty_update, state);
endinterface

// File: rtl/led_chase_seq.sv
// led_chase_seq: breathing-level ramp/hold FSM whose level is shifted down a per-channel duty chain
module led_chase_seq #(
    parameter int CHANNELS   = 8,
    parameter int DUTY_W     = 8,
    parameter int STEP_DIV   = 16,
    parameter int STEP_SIZE  = 8,
    parameter int HOLD_STEPS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    led_chase_seq_if.slave bus
);
    localparam logic [DUTY_W-1:0] MAX       = '1;
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(STEP_SIZE);
    localparam int                PW        = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int                HW        = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PW-1:0]     PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_STEPS > 0 ? HOLD_STEPS - 1 : 0);
    localparam bit                HOLDS     = HOLD_STEPS > 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    state_t            r_state;
    logic [DUTY_W-1:0] r_level;
    logic [PW-1:0]     r_pre;
    logic [HW-1:0]     r_hold_cnt;
    logic [DUTY_W-1:0] r_duty [CHANNELS];
    logic              r_duty_update;

    logic              w_step;
    logic              w_any_duty;
    logic [DUTY_W-1:0] w_new_level;
    logic [HW-1:0]     w_next_hold;
    state_t            w_next_state;

    assign w_step = bus.enable && r_state != IDLE && bus.pwm_period_end && r_pre == PRE_LAST;

    // Next level/state/hold count that a step event would apply; saturates instead of wrapping
    always_comb begin
        w_next_state = r_state;
        w_new_level  = r_level;
        w_next_hold  = r_hold_cnt;
        case (r_state)
            RAMP_UP: begin
                if (r_level > MAX - STEP) begin
                    w_new_level  = MAX;
                    w_next_hold  = '0;
                    w_next_state = HOLDS ? HOLD_HI : RAMP_DOWN;
                end else begin
                    w_new_level = r_level + STEP;
                end
            end
            RAMP_DOWN: begin
                if (r_level < STEP) begin
                    w_new_level  = '0;
                    w_next_hold  = '0;
                    w_next_state = HOLDS ? HOLD_LO : RAMP_UP;
                end else begin
                    w_new_level = r_level - STEP;
                end
            end
            HOLD_HI, HOLD_LO: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_hold  = '0;
                    w_next_state = (r_state == HOLD_HI) ? RAMP_DOWN : RAMP_UP;
                end else begin
                    w_next_hold = r_hold_cnt + HW'(1);
                end
            end
            default: ;
        endcase
    end

    // Any channel nonzero decides whether a disable produces an update pulse
    always_comb begin
        w_any_duty = 1'b0;
        for (int c = 0; c < CHANNELS; c++) w_any_duty = w_any_duty | (|r_duty[c]);
    end

    // Sequencer state, prescaler and duty chain; disable overrides a coincident step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_level       <= '0;
            r_pre         <= '0;
            r_hold_cnt    <= '0;
            r_duty_update <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) r_duty[c] <= '0;
        end else if (!bus.enable) begin
            r_state       <= IDLE;
            r_level       <= '0;
            r_pre         <= '0;
            r_hold_cnt    <= '0;
            r_duty_update <= w_any_duty;
            for (int c = 0; c < CHANNELS; c++) r_duty[c] <= '0;
        end else if (r_state == IDLE) begin
            r_state       <= RAMP_UP;
            r_level       <= '0;
            r_pre         <= '0;
            r_hold_cnt    <= '0;
            r_duty_update <= 1'b0;
        end else begin
            r_duty_update <= w_step;
            if (bus.pwm_period_end) r_pre <= w_step ? '0 : r_pre + PW'(1);
            if (w_step) begin
                r_state    <= w_next_state;
                r_level    <= w_new_level;
                r_hold_cnt <= w_next_hold;
                r_duty[0]  <= w_new_level;
                for (int c = 1; c < CHANNELS; c++) r_duty[c] <= r_duty[c-1];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_duty
        assign bus.duty[c*DUTY_W +: DUTY_W] = r_duty[c];
    end

    assign bus.duty_update = r_duty_update;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_led_chase_seq.sv
// tb_led_chase_seq: directed checks of reset, ramp/hold sequence, chase, disable and held period-end
module tb_led_chase_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   upd_cnt = 0;

    led_chase_seq_if #(.CHANNELS(8), .DUTY_W(8)) bus ();

    led_chase_seq #(
        .CHANNELS(8), .DUTY_W(8), .STEP_DIV(2), .STEP_SIZE(64), .HOLD_STEPS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_ch0 [11] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0, 8'd0, 8'd64};
    logic [2:0] exp_st  [11] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd1, 3'd1};
    logic [7:0] exp_hold [5] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd255};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (bus.duty_update) upd_cnt++;
    endtask

    task automatic pulse;
        bus.pwm_period_end = 1'b1;
        tick();
        bus.pwm_period_end = 1'b0;
    endtask

    task automatic do_step;
        repeat (3) tick();
        pulse();
        repeat (3) tick();
        pulse();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0;
        bus.pwm_period_end = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        chk("reset_state", 64'(bus.state), 64'd0);
        chk("reset_duty", bus.duty, 64'd0);
        chk("reset_upd", 64'(bus.duty_update), 64'd0);

        bus.enable = 1'b1;
        tick();
        do_step();
        chk("pre_rst_ch0", 64'(bus.duty[7:0]), 64'd64);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_duty", bus.duty, 64'd0);
        chk("async_rst_state", 64'(bus.state), 64'd0);
        chk("async_rst_upd", 64'(bus.duty_update), 64'd0);
        bus.enable = 1'b0;
        #3 rst_n = 1'b1;
        tick();

        bus.enable = 1'b1;
        tick();
        chk("enter_ramp", 64'(bus.state), 64'd1);
        chk("enter_duty", bus.duty, 64'd0);
        upd_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            do_step();
            chk($sformatf("step%0d_ch0", k + 1), 64'(bus.duty[7:0]), 64'(exp_ch0[k]));
            chk($sformatf("step%0d_state", k + 1), 64'(bus.state), 64'(exp_st[k]));
            chk($sformatf("step%0d_upd", k + 1), 64'(bus.duty_update), 64'd1);
            if (k == 3) chk("chase_step4", bus.duty, 64'h00000000_40_80_C0_FF);
        end
        chk("chase_step11", bus.duty, 64'hFFFF_BF7F_3F00_0040);
        tick();
        chk("upd_count_ramp", 64'(upd_cnt), 64'd11);

        repeat (2) tick();
        pulse();
        repeat (3) tick();
        upd_cnt = 0;
        bus.pwm_period_end = 1'b1;
        bus.enable = 1'b0;
        tick();
        bus.pwm_period_end = 1'b0;
        chk("dis_state", 64'(bus.state), 64'd0);
        chk("dis_duty", bus.duty, 64'd0);
        chk("dis_upd", 64'(bus.duty_update), 64'd1);
        repeat (2) tick();
        chk("dis_upd_after", 64'(bus.duty_update), 64'd0);
        chk("dis_upd_count", 64'(upd_cnt), 64'd1);

        bus.enable = 1'b1;
        tick();
        chk("held_enter", 64'(bus.state), 64'd1);
        bus.pwm_period_end = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("held_upd%0d", k), 64'(bus.duty_update), 64'(k % 2 == 0));
            if (k % 2 == 0) chk($sformatf("held_ch0_%0d", k), 64'(bus.duty[7:0]), 64'(exp_hold[k/2 - 1]));
        end
        chk("held_state", 64'(bus.state), 64'd3);
        bus.pwm_period_end = 1'b0;
        bus.enable = 1'b0;
        tick();
        chk("held_disable", 64'(bus.state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
